mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates an instruction-fetch port and a data port onto a
//               single shared memory port, one transaction outstanding.
//               Data has priority; a waiting fetch is forced through after
//               STARVE_LIMIT consecutive data grants. A fetch response can be
//               discarded by i_flush_i.
// Ports       : clk_i, rst_i              clock, sync active-high reset
//               i_req_i/i_addr_i          fetch request and address
//               i_gnt_o/i_rvalid_o/i_rdata_o  fetch grant and response
//               d_req_i/d_we_i/d_be_i/d_addr_i/d_wdata_i  data request
//               d_gnt_o/d_rvalid_o/d_rdata_o  data grant and response
//               m_req_o/m_we_o/m_be_o/m_addr_o/m_wdata_o  shared port request
//               m_gnt_i/m_rvalid_i/m_rdata_i  shared port handshake/response
//               i_flush_i                 drop outstanding fetch response
//               busy_o                    a transaction is in flight
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic        i_gnt_o,
    output logic        i_rvalid_o,
    output logic [31:0] i_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_be_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        m_req_o,
    output logic        m_we_o,
    output logic [3:0]  m_be_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    input  logic        m_gnt_i,
    input  logic        m_rvalid_i,
    input  logic [31:0] m_rdata_i,
    input  logic        i_flush_i,
    output logic        busy_o
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    localparam logic [3:0] c_LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_starve_cnt;
    logic        r_discard;
    logic        r_owner_fetch;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic w_idle;
    logic w_grant;
    logic w_fetch_win;
    logic w_resp_done;

    // Grants are combinational on the request lines, so they are masked while
    // reset is held to keep every output quiet during reset.
    assign w_idle      = (r_state == c_IDLE) && !rst_i;
    assign w_grant     = w_idle && (i_req_i || d_req_i);
    assign w_fetch_win = i_req_i && (!d_req_i || (r_starve_cnt >= c_LIMIT));
    assign w_resp_done = (r_state == c_RESP) && m_rvalid_i;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (i_req_i || d_req_i) w_state_nxt = c_REQ;
            c_REQ:  if (m_gnt_i)            w_state_nxt = c_RESP;
            c_RESP: if (m_rvalid_i)         w_state_nxt = c_IDLE;
            default:                        w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Captured transaction fields and starvation counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_owner_fetch <= 1'b0;
            r_we          <= 1'b0;
            r_be          <= 4'h0;
            r_addr        <= 32'h0;
            r_wdata       <= 32'h0;
            r_starve_cnt  <= 4'h0;
        end else if (w_grant) begin
            r_owner_fetch <= w_fetch_win;
            if (w_fetch_win) begin
                r_we         <= 1'b0;
                r_be         <= 4'hF;
                r_addr       <= i_addr_i;
                r_wdata      <= 32'h0;
                r_starve_cnt <= 4'h0;
            end else begin
                r_we    <= d_we_i;
                r_be    <= d_be_i;
                r_addr  <= d_addr_i;
                r_wdata <= d_wdata_i;
                // Only a data grant that made a fetch wait counts as starving it.
                if (i_req_i && (r_starve_cnt != 4'hF)) begin
                    r_starve_cnt <= r_starve_cnt + 4'h1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Fetch discard flag: set by a flush that hits an owned or just-granted
    // fetch, cleared when the transaction retires.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_discard <= 1'b0;
        end else if (w_resp_done) begin
            r_discard <= 1'b0;
        end else if (i_flush_i &&
                     (((r_state != c_IDLE) && r_owner_fetch) ||
                      (w_grant && w_fetch_win))) begin
            r_discard <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign i_gnt_o = w_grant && w_fetch_win;
    assign d_gnt_o = w_grant && !w_fetch_win;

    // A flush coinciding with the response suppresses it just like a flush
    // seen earlier in the transaction.
    assign i_rvalid_o = w_resp_done && r_owner_fetch && !r_discard && !i_flush_i;
    assign d_rvalid_o = w_resp_done && !r_owner_fetch;
    assign i_rdata_o  = i_rvalid_o ? m_rdata_i : 32'h0;
    assign d_rdata_o  = d_rvalid_o ? m_rdata_i : 32'h0;

    assign m_req_o   = (r_state == c_REQ);
    assign m_we_o    = r_we;
    assign m_be_o    = r_be;
    assign m_addr_o  = r_addr;
    assign m_wdata_o = r_wdata;

    assign busy_o = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic        i_gnt_o;
    logic        i_rvalid_o;
    logic [31:0] i_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        m_req_o;
    logic        m_we_o;
    logic [3:0]  m_be_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic        m_gnt_i;
    logic        m_rvalid_i;
    logic [31:0] m_rdata_i;
    logic        i_flush_i;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4)) u_dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_req_i    (i_req_i),
        .i_addr_i   (i_addr_i),
        .i_gnt_o    (i_gnt_o),
        .i_rvalid_o (i_rvalid_o),
        .i_rdata_o  (i_rdata_o),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_be_i     (d_be_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_gnt_o    (d_gnt_o),
        .d_rvalid_o (d_rvalid_o),
        .d_rdata_o  (d_rdata_o),
        .m_req_o    (m_req_o),
        .m_we_o     (m_we_o),
        .m_be_o     (m_be_o),
        .m_addr_o   (m_addr_o),
        .m_wdata_o  (m_wdata_o),
        .m_gnt_i    (m_gnt_i),
        .m_rvalid_i (m_rvalid_i),
        .m_rdata_i  (m_rdata_i),
        .i_flush_i  (i_flush_i),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Called right after the grant edge (state REQ). Memory accepts at once
    // and responds the following cycle; checks the routed response.
    task automatic complete(input string tag, input logic [31:0] data,
                            input logic exp_i, input logic exp_d);
        m_gnt_i = 1'b1;
        #1;
        check({tag, "_mreq"}, m_req_o, 1);
        tick();
        m_gnt_i    = 1'b0;
        m_rvalid_i = 1'b1;
        m_rdata_i  = data;
        #1;
        check({tag, "_irv"}, i_rvalid_o, exp_i);
        check({tag, "_drv"}, d_rvalid_o, exp_d);
        check({tag, "_ird"}, i_rdata_o, exp_i ? data : 32'h0);
        check({tag, "_drd"}, d_rdata_o, exp_d ? data : 32'h0);
        tick();
        m_rvalid_i = 1'b0;
        m_rdata_i  = 32'h0;
    endtask

    initial begin
        rst_i = 1'b1; i_req_i = 1'b0; i_addr_i = 32'h0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = 4'h0; d_addr_i = 32'h0; d_wdata_i = 32'h0;
        m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = 32'h0; i_flush_i = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_busy", busy_o, 0);
        check("rst_mreq", m_req_o, 0);
        check("rst_maddr", m_addr_o, 0);
        check("rst_mbe", m_be_o, 0);
        rst_i = 1'b0;
        tick();

        // Fetch read
        i_req_i = 1'b1; i_addr_i = 32'h100;
        #1;
        check("f_igi", i_gnt_o, 1);
        check("f_dg", d_gnt_o, 0);
        tick();
        i_req_i = 1'b0;
        check("f_maddr", m_addr_o, 32'h100);
        check("f_mwe", m_we_o, 0);
        check("f_mbe", m_be_o, 4'hF);
        check("f_busy", busy_o, 1);
        complete("f", 32'hDEADBEEF, 1'b1, 1'b0);
        check("f_idle", busy_o, 0);

        // Simultaneous requests: data first, fetch after the write ack
        i_req_i = 1'b1; i_addr_i = 32'h104;
        d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011; d_addr_i = 32'h40; d_wdata_i = 32'h12345678;
        #1;
        check("s_dg", d_gnt_o, 1);
        check("s_ig", i_gnt_o, 0);
        tick();
        d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = 4'h0; d_addr_i = 32'h0; d_wdata_i = 32'h0;
        check("s_mwe", m_we_o, 1);
        check("s_mbe", m_be_o, 4'b0011);
        check("s_maddr", m_addr_o, 32'h40);
        check("s_mwd", m_wdata_o, 32'h12345678);
        check("s_ig_req", i_gnt_o, 0);
        complete("s_w", 32'h0, 1'b0, 1'b1);
        #1;
        check("s_ig2", i_gnt_o, 1);
        tick();
        i_req_i = 1'b0;
        check("s_maddr2", m_addr_o, 32'h104);
        complete("s_f", 32'hA5A5_0001, 1'b1, 1'b0);

        // Starvation: four data grants, then the fetch is forced through
        i_req_i = 1'b1; i_addr_i = 32'h180;
        d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_addr_i = 32'h900;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("st%0d_dg", k), d_gnt_o, (k < 4) ? 1 : 0);
            check($sformatf("st%0d_ig", k), i_gnt_o, (k == 4) ? 1 : 0);
            tick();
            complete($sformatf("st%0d", k), 32'h1000 + k, k == 4, k < 4);
        end
        // Counter cleared by the fetch win, so data wins again
        #1;
        check("st_clr_dg", d_gnt_o, 1);
        check("st_clr_ig", i_gnt_o, 0);
        tick();
        i_req_i = 1'b0; d_req_i = 1'b0;
        complete("st_clr", 32'h2000, 1'b0, 1'b1);

        // Flush during RESP drops the fetch response
        i_req_i = 1'b1; i_addr_i = 32'h200;
        #1;
        check("fl_ig", i_gnt_o, 1);
        tick();
        i_req_i = 1'b0;
        m_gnt_i = 1'b1;
        tick();
        m_gnt_i = 1'b0; i_flush_i = 1'b1;
        tick();
        i_flush_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'hCAFEF00D;
        #1;
        check("fl_irv", i_rvalid_o, 0);
        check("fl_ird", i_rdata_o, 0);
        tick();
        m_rvalid_i = 1'b0; m_rdata_i = 32'h0;
        check("fl_idle", busy_o, 0);
        i_req_i = 1'b1; i_addr_i = 32'h300;
        #1;
        check("fl_ig2", i_gnt_o, 1);
        tick();
        i_req_i = 1'b0;
        complete("fl_next", 32'h0BADF00D, 1'b1, 1'b0);

        // Flush coinciding with the fetch response
        i_req_i = 1'b1; i_addr_i = 32'h304;
        tick();
        i_req_i = 1'b0;
        m_gnt_i = 1'b1;
        tick();
        m_gnt_i = 1'b0; i_flush_i = 1'b1; m_rvalid_i = 1'b1; m_rdata_i = 32'h77;
        #1;
        check("flc_irv", i_rvalid_o, 0);
        tick();
        i_flush_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = 32'h0;

        // Flush does not affect a data read
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h500;
        tick();
        d_req_i = 1'b0;
        i_flush_i = 1'b1;
        complete("fld", 32'h5555AAAA, 1'b0, 1'b1);
        i_flush_i = 1'b0;

        // Memory backpressure holds the request, no new grant
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h80;
        #1;
        check("bp_dg", d_gnt_o, 1);
        tick();
        d_req_i = 1'b0; i_req_i = 1'b1; i_addr_i = 32'h400;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp%0d_mreq", k), m_req_o, 1);
            check($sformatf("bp%0d_maddr", k), m_addr_o, 32'h80);
            check($sformatf("bp%0d_busy", k), busy_o, 1);
            check($sformatf("bp%0d_gnt", k), {i_gnt_o, d_gnt_o}, 0);
            tick();
        end
        complete("bp", 32'h8888, 1'b0, 1'b1);
        #1;
        check("bp_ig", i_gnt_o, 1);
        tick();
        i_req_i = 1'b0;
        complete("bp_f", 32'h4444, 1'b1, 1'b0);

        // Reset in RESP abandons the transaction
        i_req_i = 1'b1; i_addr_i = 32'h600;
        tick();
        i_req_i = 1'b0;
        m_gnt_i = 1'b1;
        tick();
        m_gnt_i = 1'b0;
        #1;
        check("rr_busy_resp", busy_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h99;
        #1;
        check("rr_irv", i_rvalid_o, 0);
        check("rr_ird", i_rdata_o, 0);
        check("rr_busy", busy_o, 0);
        check("rr_mreq", m_req_o, 0);
        check("rr_maddr", m_addr_o, 0);
        check("rr_mbe", m_be_o, 0);
        tick();
        m_rvalid_i = 1'b0; m_rdata_i = 32'h0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
